// File: rtl/tea_serial_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tea_serial_bridge
// Purpose  : Host-side bridge between a narrow serial word port and the
//            parallel operand/result bus of the TEA cipher core. Operands are
//            loaded word by word, a cipher/decipher command starts the core,
//            results are captured on core completion and streamed back one
//            word at a time. A timeout aborts a core that never completes.
// Revision : 1.0 - initial release
// ============================================================================
module tea_serial_bridge #(
    parameter int WORD_SIZE = 128,
    parameter int N_IN      = 6,
    parameter int N_OUT     = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_SIZE-1:0]         serial_port_in,
    input  logic                         iInValid,
    output logic                         oInReady,
    input  logic                         iStartCipher,
    input  logic                         iStartDecipher,
    output logic [WORD_SIZE-1:0]         serial_port_out,
    output logic                         oOutValid,
    input  logic                         iOutReady,
    output logic                         oDoneCipher,
    output logic                         oDoneDecipher,
    output logic                         oError,
    output logic                         oBusy,
    output logic [N_IN*WORD_SIZE-1:0]    oCoreIn,
    output logic                         oStartCipher,
    output logic                         oStartDecipher,
    input  logic [N_OUT*WORD_SIZE-1:0]   iCoreOut,
    input  logic                         iDoneCipher,
    input  logic                         iDoneDecipher
);

    localparam int IN_W  = $clog2(N_IN);
    localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);

    localparam logic [IN_W-1:0]  c_IN_LAST  = IN_W'(N_IN - 1);
    localparam logic [OUT_W-1:0] c_OUT_LAST = OUT_W'(N_OUT - 1);
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_UNLOAD = 2'd3
    } state_t;

    state_t                      r_state;
    logic                        r_modeCipher;
    logic [IN_W-1:0]             r_inCount;
    logic [OUT_W-1:0]            r_outCount;
    logic [TMR_W-1:0]            r_timer;
    logic [N_IN*WORD_SIZE-1:0]   r_coreIn;
    logic [WORD_SIZE-1:0]        r_buf [N_OUT];
    logic [WORD_SIZE-1:0]        r_dataOut;
    logic                        r_startCipher;
    logic                        r_startDecipher;
    logic                        r_doneCipher;
    logic                        r_doneDecipher;
    logic                        r_error;

    logic [OUT_W-1:0]            w_nextOut;
    logic                        w_coreDone;

    assign w_nextOut  = r_outCount + OUT_W'(1);
    // Only the completion of the mode that was started counts.
    assign w_coreDone = r_modeCipher ? iDoneCipher : iDoneDecipher;

    assign oInReady        = (r_state == ST_LOAD);
    assign oOutValid       = (r_state == ST_UNLOAD);
    assign oBusy           = (r_state != ST_LOAD);
    assign serial_port_out = r_dataOut;
    assign oCoreIn         = r_coreIn;
    assign oStartCipher    = r_startCipher;
    assign oStartDecipher  = r_startDecipher;
    assign oDoneCipher     = r_doneCipher;
    assign oDoneDecipher   = r_doneDecipher;
    assign oError          = r_error;

    // Bridge sequencer: load operands, arm, wait for the core, stream results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_LOAD;
            r_modeCipher    <= 1'b0;
            r_inCount       <= '0;
            r_outCount      <= '0;
            r_timer         <= '0;
            r_coreIn        <= '0;
            r_dataOut       <= '0;
            r_startCipher   <= 1'b0;
            r_startDecipher <= 1'b0;
            r_doneCipher    <= 1'b0;
            r_doneDecipher  <= 1'b0;
            r_error         <= 1'b0;
            for (int j = 0; j < N_OUT; j++) begin
                r_buf[j] <= '0;
            end
        end else begin
            // Start and done strobes are single-cycle pulses.
            r_startCipher   <= 1'b0;
            r_startDecipher <= 1'b0;
            r_doneCipher    <= 1'b0;
            r_doneDecipher  <= 1'b0;

            case (r_state)
                ST_LOAD: begin
                    if (iInValid) begin
                        for (int i = 0; i < N_IN; i++) begin
                            if (r_inCount == IN_W'(i)) begin
                                r_coreIn[i*WORD_SIZE +: WORD_SIZE] <= serial_port_in;
                            end
                        end
                        r_error <= 1'b0;
                        if (r_inCount == c_IN_LAST) begin
                            r_inCount <= '0;
                            r_state   <= ST_ARMED;
                        end else begin
                            r_inCount <= r_inCount + IN_W'(1);
                        end
                    end
                end

                ST_ARMED: begin
                    // Cipher takes priority when both commands arrive together.
                    if (iStartCipher) begin
                        r_modeCipher  <= 1'b1;
                        r_startCipher <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= ST_WAIT;
                    end else if (iStartDecipher) begin
                        r_modeCipher    <= 1'b0;
                        r_startDecipher <= 1'b1;
                        r_timer         <= '0;
                        r_state         <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Completion beats a timeout landing in the same cycle.
                    if (w_coreDone) begin
                        for (int j = 0; j < N_OUT; j++) begin
                            r_buf[j] <= iCoreOut[j*WORD_SIZE +: WORD_SIZE];
                        end
                        r_dataOut  <= iCoreOut[0 +: WORD_SIZE];
                        r_outCount <= '0;
                        r_state    <= ST_UNLOAD;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_error <= 1'b1;
                        r_state <= ST_LOAD;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end

                ST_UNLOAD: begin
                    if (iOutReady) begin
                        if (r_outCount == c_OUT_LAST) begin
                            r_outCount     <= '0;
                            r_state        <= ST_LOAD;
                            r_doneCipher   <= r_modeCipher;
                            r_doneDecipher <= ~r_modeCipher;
                        end else begin
                            r_outCount <= w_nextOut;
                            for (int j = 0; j < N_OUT; j++) begin
                                if (w_nextOut == OUT_W'(j)) begin
                                    r_dataOut <= r_buf[j];
                                end
                            end
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tea_serial_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_tea_serial_bridge
// Purpose  : Self-checking bench for tea_serial_bridge with a behavioural
//            core stand-in and an operand/result reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tea_serial_bridge;

    localparam int W   = 128;
    localparam int NI  = 6;
    localparam int NO  = 4;
    localparam int TMO = 40;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [W-1:0]      serial_port_in = '0;
    logic              iInValid = 1'b0;
    logic              oInReady;
    logic              iStartCipher = 1'b0;
    logic              iStartDecipher = 1'b0;
    logic [W-1:0]      serial_port_out;
    logic              oOutValid;
    logic              iOutReady = 1'b0;
    logic              oDoneCipher;
    logic              oDoneDecipher;
    logic              oError;
    logic              oBusy;
    logic [NI*W-1:0]   oCoreIn;
    logic              oStartCipher;
    logic              oStartDecipher;
    logic [NO*W-1:0]   iCoreOut = '0;
    logic              iDoneCipher = 1'b0;
    logic              iDoneDecipher = 1'b0;

    tea_serial_bridge #(
        .WORD_SIZE (W),
        .N_IN      (NI),
        .N_OUT     (NO),
        .TIMEOUT   (TMO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .serial_port_in  (serial_port_in),
        .iInValid        (iInValid),
        .oInReady        (oInReady),
        .iStartCipher    (iStartCipher),
        .iStartDecipher  (iStartDecipher),
        .serial_port_out (serial_port_out),
        .oOutValid       (oOutValid),
        .iOutReady       (iOutReady),
        .oDoneCipher     (oDoneCipher),
        .oDoneDecipher   (oDoneDecipher),
        .oError          (oError),
        .oBusy           (oBusy),
        .oCoreIn         (oCoreIn),
        .oStartCipher    (oStartCipher),
        .oStartDecipher  (oStartDecipher),
        .iCoreOut        (iCoreOut),
        .iDoneCipher     (iDoneCipher),
        .iDoneDecipher   (iDoneDecipher)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: operand words as the host wrote them, results the
    // core stand-in will return, and the sticky timeout flag.
    logic [W-1:0] expIn  [NI];
    logic [W-1:0] expOut [NO];
    logic         expErr = 1'b0;

    function automatic logic [NI*W-1:0] packIn();
        logic [NI*W-1:0] r;
        for (int i = 0; i < NI; i++) r[i*W +: W] = expIn[i];
        return r;
    endfunction

    function automatic logic [W-1:0] rndWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [NI*W-1:0] obs, input logic [NI*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic driveCore(input bit useModel);
        for (int j = 0; j < NO; j++) iCoreOut[j*W +: W] = useModel ? expOut[j] : rndWord();
    endtask

    task automatic writeWord(input int idx, input logic [W-1:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            iOutReady = 1'($urandom_range(0, 1));
            tick();
        end
        iOutReady      = 1'b0;
        serial_port_in = d;
        iInValid       = 1'b1;
        tick();
        iInValid       = 1'b0;
        serial_port_in = rndWord();
        expIn[idx]     = d;
        expErr         = 1'b0;
        check("coreIn_after_write", oCoreIn, packIn());
        check("error_after_write", oError, expErr);
    endtask

    task automatic loadAll(input int gapMax);
        for (int i = 0; i < NI; i++) writeWord(i, rndWord(), $urandom_range(0, gapMax));
        check("armed_inReady", oInReady, 1'b0);
        check("armed_busy", oBusy, 1'b1);
    endtask

    task automatic runOp(input bit cipher, input bit both, input int lat, input bit toggle);
        int n;
        int k;
        bit rdy;
        driveCore(1'b1);
        if (both) begin
            iStartCipher   = 1'b1;
            iStartDecipher = 1'b1;
        end else begin
            iStartCipher   = cipher;
            iStartDecipher = !cipher;
        end
        tick();
        iStartCipher   = 1'b0;
        iStartDecipher = 1'b0;
        check("startCipher_pulse", oStartCipher, cipher);
        check("startDecipher_pulse", oStartDecipher, !cipher);
        check("wait_busy", oBusy, 1'b1);
        // Core latency with noise: writes, stray commands, wrong-mode done.
        for (int i = 0; i < lat; i++) begin
            iInValid       = 1'b1;
            serial_port_in = rndWord();
            iStartCipher   = 1'($urandom_range(0, 1));
            iDoneCipher    = (i == 0) && !cipher;
            iDoneDecipher  = (i == 0) && cipher;
            tick();
            check("wait_no_start", {oStartCipher, oStartDecipher}, 2'b00);
            check("wait_no_outValid", oOutValid, 1'b0);
            check("wait_coreIn_held", oCoreIn, packIn());
        end
        iInValid      = 1'b0;
        iStartCipher  = 1'b0;
        iDoneCipher   = cipher;
        iDoneDecipher = !cipher;
        tick();
        iDoneCipher   = 1'b0;
        iDoneDecipher = 1'b0;
        driveCore(1'b0);
        check("capture_outValid", oOutValid, 1'b1);
        n = 0;
        k = 0;
        while (k < NO) begin
            check("unload_valid", oOutValid, 1'b1);
            check("unload_word", serial_port_out, expOut[k]);
            check("unload_no_done", {oDoneCipher, oDoneDecipher}, 2'b00);
            rdy       = toggle ? n[0] : 1'b1;
            iOutReady = rdy;
            tick();
            n++;
            if (rdy) k++;
        end
        iOutReady = 1'b0;
        check("unload_cycles", n, toggle ? 2*NO : NO);
        check("doneCipher_pulse", oDoneCipher, cipher);
        check("doneDecipher_pulse", oDoneDecipher, !cipher);
        check("after_unload_outValid", oOutValid, 1'b0);
        check("after_unload_inReady", oInReady, 1'b1);
        check("after_unload_busy", oBusy, 1'b0);
        tick();
        check("done_single_cycle", {oDoneCipher, oDoneDecipher}, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) expIn[i] = '0;
        for (int j = 0; j < NO; j++) expOut[j] = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_inReady", oInReady, 1'b1);
        check("rst_outValid", oOutValid, 1'b0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_error", oError, 1'b0);
        check("rst_dataOut", serial_port_out, '0);
        check("rst_coreIn", oCoreIn, '0);
        check("rst_strobes", {oStartCipher, oStartDecipher, oDoneCipher, oDoneDecipher}, 4'b0);
        rst = 1'b0;
        tick();
        check("post_rst_inReady", oInReady, 1'b1);

        // Directed op: words 1..6 with gaps, start attempt in LOAD after 3
        // words, simultaneous start commands, results A..D after 32 cycles.
        for (int i = 0; i < 3; i++) writeWord(i, W'(i + 1), 1 + (i % 2));
        iStartCipher   = 1'b1;
        iStartDecipher = 1'b1;
        tick();
        iStartCipher   = 1'b0;
        iStartDecipher = 1'b0;
        check("load_start_ignored", {oStartCipher, oStartDecipher}, 2'b00);
        check("load_start_still_ready", oInReady, 1'b1);
        check("load_start_coreIn", oCoreIn, packIn());
        for (int i = 3; i < NI; i++) writeWord(i, W'(i + 1), 2);
        check("armed_inReady", oInReady, 1'b0);
        for (int j = 0; j < NO; j++) expOut[j] = W'(10 + j);
        runOp(1'b1, 1'b1, 32, 1'b0);

        // Decipher with iOutReady toggling
        loadAll(2);
        for (int j = 0; j < NO; j++) expOut[j] = rndWord();
        runOp(1'b0, 1'b0, $urandom_range(1, 20), 1'b1);

        // Timeout: core never finishes; writes and wrong-mode done ignored
        loadAll(1);
        iStartCipher = 1'b1;
        tick();
        iStartCipher = 1'b0;
        check("tmo_start", oStartCipher, 1'b1);
        for (int i = 1; i < TMO; i++) begin
            iInValid       = 1'b1;
            serial_port_in = rndWord();
            iDoneDecipher  = 1'b1;
            tick();
            check("tmo_no_error_yet", oError, 1'b0);
            check("tmo_no_outValid", oOutValid, 1'b0);
            check("tmo_coreIn_held", oCoreIn, packIn());
        end
        iInValid      = 1'b0;
        iDoneDecipher = 1'b0;
        tick();
        expErr = 1'b1;
        check("tmo_error", oError, expErr);
        check("tmo_inReady", oInReady, 1'b1);
        check("tmo_busy", oBusy, 1'b0);
        check("tmo_outValid", oOutValid, 1'b0);
        tick();
        check("tmo_error_sticky", oError, expErr);
        check("tmo_no_done", {oDoneCipher, oDoneDecipher}, 2'b00);

        // Next write clears the error; done on the last timer cycle still wins
        loadAll(1);
        for (int j = 0; j < NO; j++) expOut[j] = rndWord();
        runOp(1'b1, 1'b0, TMO - 1, 1'b0);
        check("boundary_no_error", oError, 1'b0);

        // Done on the first WAIT cycle
        loadAll(0);
        for (int j = 0; j < NO; j++) expOut[j] = rndWord();
        runOp(1'b0, 1'b0, 0, 1'b0);

        // Randomised operations
        for (int r = 0; r < 4; r++) begin
            bit both;
            bit cipher;
            both   = 1'($urandom_range(0, 1));
            cipher = both ? 1'b1 : 1'($urandom_range(0, 1));
            loadAll(2);
            for (int j = 0; j < NO; j++) expOut[j] = rndWord();
            runOp(cipher, both, $urandom_range(0, TMO - 1), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of unloading (after two words accepted)
        loadAll(1);
        for (int j = 0; j < NO; j++) expOut[j] = rndWord();
        driveCore(1'b1);
        iStartDecipher = 1'b1;
        tick();
        iStartDecipher = 1'b0;
        repeat (5) tick();
        iDoneDecipher = 1'b1;
        tick();
        iDoneDecipher = 1'b0;
        check("mid_capture_word0", serial_port_out, expOut[0]);
        iOutReady = 1'b1;
        tick();
        tick();
        iOutReady = 1'b0;
        check("mid_word2", serial_port_out, expOut[2]);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) expIn[i] = '0;
        check("midrst_outValid", oOutValid, 1'b0);
        check("midrst_inReady", oInReady, 1'b1);
        check("midrst_dataOut", serial_port_out, '0);
        check("midrst_done", {oDoneCipher, oDoneDecipher}, 2'b00);
        check("midrst_coreIn", oCoreIn, packIn());
        check("midrst_busy", oBusy, 1'b0);

        // Recovery after reset
        loadAll(1);
        for (int j = 0; j < NO; j++) expOut[j] = rndWord();
        runOp(1'b1, 1'b0, $urandom_range(0, 10), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
